// File: rtl/bram_lsu_pkg.sv
// Shared encodings for the BRAM load/store unit: access sizes, FSM states
// and the request legality check.
package bram_lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_B   = 2'b00,
    SIZE_H   = 2'b01,
    SIZE_W   = 2'b10,
    SIZE_RSV = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    RMW  = 2'b10
  } state_e;

  // A request is rejected for a reserved size, a misaligned halfword/word,
  // or a word index beyond the attached memory.
  function automatic logic req_is_bad(input logic [1:0] size,
                                      input logic [31:0] addr,
                                      input int unsigned depth);
    logic bad;
    bad = 1'b0;
    if (size == SIZE_RSV) bad = 1'b1;
    if ((size == SIZE_H) && addr[0]) bad = 1'b1;
    if ((size == SIZE_W) && (addr[1:0] != 2'b00)) bad = 1'b1;
    if ({2'b00, addr[31:2]} >= 32'(depth)) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/bram_lsu_if.sv
// CPU-side request/response bundle of the load/store unit.
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; request fields are only meaningful while
// req_valid is high. rsp_valid is a single-cycle pulse with no back-pressure;
// rsp_err and rsp_rdata are meaningful only alongside it and read 0 otherwise.
interface bram_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata
  );
endinterface

// File: rtl/bram_lsu_mem_lane_align.sv
// Combinational byte-lane logic: little-endian lane extraction with sign or
// zero extension for loads, and lane merge into an existing word for stores.
// Kept free of state so an instruction-fetch path can reuse it.
module mem_lane_align
  import bram_lsu_pkg::*;
(
  input  logic [31:0] ld_word_i,
  input  logic [1:0]  ld_offset_i,
  input  logic [1:0]  ld_size_i,
  input  logic        ld_unsigned_i,
  output logic [31:0] ld_data_o,
  input  logic [31:0] st_old_i,
  input  logic [31:0] st_new_i,
  input  logic [1:0]  st_offset_i,
  input  logic [1:0]  st_size_i,
  output logic [31:0] st_merged_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Load path: pick the addressed lane, then extend to 32 bits.
  always_comb begin
    ld_byte   = ld_word_i[{ld_offset_i, 3'b000} +: 8];
    ld_half   = ld_offset_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
    ld_data_o = ld_word_i;
    if (ld_size_i == SIZE_B)
      ld_data_o = {{24{~ld_unsigned_i & ld_byte[7]}}, ld_byte};
    else if (ld_size_i == SIZE_H)
      ld_data_o = {{16{~ld_unsigned_i & ld_half[15]}}, ld_half};
  end

  // Store path: overwrite only the addressed lane, keep the other bits.
  always_comb begin
    st_merged_o = st_new_i;
    if (st_size_i == SIZE_B) begin
      st_merged_o = st_old_i;
      st_merged_o[{st_offset_i, 3'b000} +: 8] = st_new_i[7:0];
    end else if (st_size_i == SIZE_H) begin
      st_merged_o = st_old_i;
      if (st_offset_i[1]) st_merged_o[31:16] = st_new_i[15:0];
      else                st_merged_o[15:0]  = st_new_i[15:0];
    end
  end

endmodule

// File: rtl/bram_lsu.sv
// Load/store unit in front of a single-port, word-addressed BRAM with a
// one-cycle registered read. Word stores complete in the accept cycle;
// loads and sub-word stores (read-modify-write) take one extra cycle.
module bram_lsu
  import bram_lsu_pkg::*;
#(
  parameter int unsigned DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  bram_lsu_if.slave   cpu,
  output logic [31:0] mem_address,
  output logic        mem_write_en,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output state_e      state_o
);

  state_e      state_q, state_d;
  logic [29:0] idx_q, idx_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [15:0] wdata_q, wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  logic        req_ready;
  logic        accept;
  logic        bad;
  logic [31:0] ld_data;
  logic [31:0] st_merged;

  mem_lane_align u_align (
    .ld_word_i     (mem_read_data),
    .ld_offset_i   (off_q),
    .ld_size_i     (size_q),
    .ld_unsigned_i (uns_q),
    .ld_data_o     (ld_data),
    .st_old_i      (mem_read_data),
    .st_new_i      ({16'h0000, wdata_q}),
    .st_offset_i   (off_q),
    .st_size_i     (size_q),
    .st_merged_o   (st_merged)
  );

  assign cpu.req_ready = req_ready;
  assign cpu.rsp_valid = rsp_valid_q;
  assign cpu.rsp_err   = rsp_err_q;
  assign cpu.rsp_rdata = rsp_rdata_q;
  assign state_o       = state_q;

  // Next-state, memory port and response logic; IDLE drives the memory
  // straight from the request so reads and word writes start at accept.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    off_d          = off_q;
    size_d         = size_q;
    uns_d          = uns_q;
    wdata_d        = wdata_q;
    rsp_valid_d    = 1'b0;
    rsp_err_d      = 1'b0;
    rsp_rdata_d    = 32'h0;
    req_ready      = 1'b0;
    accept         = 1'b0;
    bad            = req_is_bad(cpu.req_size, cpu.req_addr, DEPTH);
    mem_address    = {2'b00, idx_q};
    mem_write_en   = 1'b0;
    mem_write_data = st_merged;
    case (state_q)
      IDLE: begin
        req_ready      = rst_n;
        accept         = cpu.req_valid & req_ready;
        mem_address    = {2'b00, cpu.req_addr[31:2]};
        mem_write_data = cpu.req_wdata;
        if (accept) begin
          if (bad) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (cpu.req_write && (cpu.req_size == SIZE_W)) begin
            mem_write_en = 1'b1;
            rsp_valid_d  = 1'b1;
          end else begin
            idx_d   = cpu.req_addr[31:2];
            off_d   = cpu.req_addr[1:0];
            size_d  = cpu.req_size;
            uns_d   = cpu.req_unsigned;
            wdata_d = cpu.req_wdata[15:0];
            state_d = cpu.req_write ? RMW : LOAD;
          end
        end
      end
      LOAD: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = ld_data;
        state_d     = IDLE;
      end
      RMW: begin
        mem_write_en = rst_n;
        rsp_valid_d  = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched request and registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      off_q       <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      off_q       <= off_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_bram_lsu.sv
// Bench for bram_lsu: BRAM model, directed scenarios and random traffic
// scored against a byte-array reference of memory contents.
module tb_bram_lsu;
  import bram_lsu_pkg::*;

  localparam int DEPTH = 64;
  localparam int AW    = $clog2(DEPTH);

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  bram_lsu_if cpu();
  logic [31:0] mem_address;
  logic        mem_write_en;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  state_e      dut_state;

  bram_lsu #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cpu            (cpu.slave),
    .mem_address    (mem_address),
    .mem_write_en   (mem_write_en),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .state_o        (dut_state)
  );

  // Single-port BRAM, registered read, write-first.
  logic [31:0] bram [DEPTH];
  always @(posedge clk) begin
    if (mem_address < DEPTH) begin
      if (mem_write_en) begin
        bram[mem_address[AW-1:0]] <= mem_write_data;
        mem_read_data <= mem_write_data;
      end else begin
        mem_read_data <= bram[mem_address[AW-1:0]];
      end
    end else begin
      mem_read_data <= 32'h0;
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] ref_bytes [DEPTH*4];

  function automatic logic ref_bad(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd3) return 1'b1;
    if (sz == 2'd1 && (a % 2) != 0) return 1'b1;
    if (sz == 2'd2 && (a % 4) != 0) return 1'b1;
    if ((a / 4) >= DEPTH) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic [31:0] a, input logic u);
    int n;
    longint v;
    n = 1 << sz;
    v = 0;
    for (int i = 0; i < n; i++) v += longint'(ref_bytes[int'(a) + i]) << (8 * i);
    if (!u && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int n;
    n = 1 << sz;
    for (int i = 0; i < n; i++) ref_bytes[int'(a) + i] = wd[8*i +: 8];
  endtask

  function automatic logic [31:0] ref_word(input int idx);
    return {ref_bytes[idx*4+3], ref_bytes[idx*4+2], ref_bytes[idx*4+1], ref_bytes[idx*4]};
  endfunction

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q[$];      // {err, rdata}
  int          exp_cyc_q[$];  // cycle count at which the response is due
  logic [31:0] last_rdata = 32'h0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (cpu.rsp_valid) begin
        last_rdata = cpu.rsp_rdata;
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 32'(cpu.rsp_valid), 32'h0);
        end else begin
          logic [32:0] e;
          int c;
          e = exp_q.pop_front();
          c = exp_cyc_q.pop_front();
          check("rsp_cycle", 32'(cyc), 32'(c));
          check("rsp_err", 32'(cpu.rsp_err), 32'(e[32]));
          check("rsp_rdata", cpu.rsp_rdata, e[31:0]);
        end
      end else begin
        check("rsp_idle_zero", cpu.rsp_rdata | 32'(cpu.rsp_err), 32'h0);
      end
    end
  end

  // ---------------- driver ----------------
  int          last_wait;
  logic [31:0] last_addr;
  logic        last_we;

  // Called at a falling edge; returns at the falling edge after accept.
  task automatic send(input logic w, input logic [1:0] sz, input logic u,
                      input logic [31:0] a, input logic [31:0] wd);
    int guard;
    int lat;
    logic [32:0] e;
    guard = 0;
    cpu.req_valid = 1'b0;
    while (!cpu.req_ready && guard < 16) begin
      @(negedge clk);
      guard++;
    end
    last_wait = guard;
    if (guard >= 16) begin
      check("ready_timeout", 32'(cpu.req_ready), 32'h1);
      return;
    end
    cpu.req_write    = w;
    cpu.req_size     = sz;
    cpu.req_unsigned = u;
    cpu.req_addr     = a;
    cpu.req_wdata    = wd;
    cpu.req_valid    = 1'b1;
    if (ref_bad(sz, a)) begin
      e = {1'b1, 32'h0};
      lat = 1;
    end else if (w) begin
      ref_store(sz, a, wd);
      e = {1'b0, 32'h0};
      lat = (sz == 2'd2) ? 1 : 2;
    end else begin
      e = {1'b0, ref_load(sz, a, u)};
      lat = 2;
    end
    exp_q.push_back(e);
    exp_cyc_q.push_back(cyc + lat);
    #1;
    last_addr = mem_address;
    last_we   = mem_write_en;
    @(negedge clk);
    cpu.req_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 20) begin
      @(negedge clk);
      g++;
    end
    check("drain", 32'(exp_q.size()), 32'h0);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] byte_exp [5];

  initial begin
    cpu.req_valid    = 1'b0;
    cpu.req_write    = 1'b0;
    cpu.req_size     = 2'd0;
    cpu.req_unsigned = 1'b0;
    cpu.req_addr     = 32'h0;
    cpu.req_wdata    = 32'h0;
    for (int i = 0; i < DEPTH; i++) bram[i] = 32'h0;
    for (int i = 0; i < DEPTH*4; i++) ref_bytes[i] = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", 32'(cpu.req_ready), 32'h0);
    check("rst_we", 32'(mem_write_en), 32'h0);
    check("rst_rsp_valid", 32'(cpu.rsp_valid), 32'h0);
    check("rst_rdata", cpu.rsp_rdata, 32'h0);
    check("rst_state", 32'(dut_state), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Word store then word load
    send(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
    check("ws_addr", last_addr, 32'd4);
    check("ws_we", 32'(last_we), 32'h1);
    send(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    drain();
    check("wl_data", last_rdata, 32'hDEADBEEF);

    // Byte loads with sign/zero extension
    send(1'b1, 2'd2, 1'b0, 32'h10, 32'h80FF7F01);
    byte_exp[0] = 32'h00000001;
    byte_exp[1] = 32'h0000007F;
    byte_exp[2] = 32'hFFFFFFFF;
    byte_exp[3] = 32'hFFFFFF80;
    byte_exp[4] = 32'h00000080;
    for (int i = 0; i < 5; i++) begin
      send(1'b0, 2'd0, (i == 4), 32'h10 + 32'(i == 4 ? 3 : i), 32'h0);
      drain();
      check($sformatf("bl_%0d", i), last_rdata, byte_exp[i]);
    end

    // Sub-word stores via read-modify-write
    send(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344);
    send(1'b1, 2'd0, 1'b0, 32'h12, 32'h000000AA);
    check("rmw_ready", 32'(cpu.req_ready), 32'h0);
    check("rmw_state", 32'(dut_state), 32'(RMW));
    drain();
    check("rmw_byte", bram[4], 32'h11AA3344);
    send(1'b1, 2'd1, 1'b0, 32'h10, 32'h0000BEEF);
    check("rmw_ready_h", 32'(cpu.req_ready), 32'h0);
    drain();
    check("rmw_half", bram[4], 32'h11AABEEF);

    // Rejected requests
    send(1'b0, 2'd1, 1'b0, 32'h11, 32'h0);
    check("err_we_h", 32'(last_we), 32'h0);
    send(1'b1, 2'd2, 1'b0, 32'h12, 32'h12345678);
    check("err_we_w", 32'(last_we), 32'h0);
    send(1'b0, 2'd3, 1'b0, 32'h0, 32'h0);
    check("err_we_rsv", 32'(last_we), 32'h0);
    send(1'b0, 2'd2, 1'b0, 32'(DEPTH*4), 32'h0);
    check("err_we_oor", 32'(last_we), 32'h0);
    drain();
    check("err_mem_kept", bram[4], 32'h11AABEEF);

    // Back-to-back word stores
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 2'd2, 1'b0, 32'(i*4), $urandom);
      if (i > 0) check("b2b_wait", 32'(last_wait), 32'h0);
      check("b2b_we", 32'(last_we), 32'h1);
    end
    drain();

    // Reset during RMW abandons the write and the response
    send(1'b1, 2'd2, 1'b0, 32'h20, 32'h12345678);
    drain();
    cpu.req_write = 1'b1;
    cpu.req_size  = 2'd0;
    cpu.req_addr  = 32'h20;
    cpu.req_wdata = 32'h000000AB;
    cpu.req_valid = 1'b1;
    @(negedge clk);
    cpu.req_valid = 1'b0;
    check("rst_mid_state_rmw", 32'(dut_state), 32'(RMW));
    rst_n = 1'b0;
    #1;
    check("rst_mid_state", 32'(dut_state), 32'(IDLE));
    check("rst_mid_we", 32'(mem_write_en), 32'h0);
    repeat (3) @(negedge clk);
    check("rst_mid_word8", bram[8], 32'h12345678);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_rel_ready", 32'(cpu.req_ready), 32'h1);
    check("rst_rel_state", 32'(dut_state), 32'(IDLE));
    check("rst_rel_rsp", 32'(cpu.rsp_valid), 32'h0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      if ($urandom_range(0, 9) == 0) a = 32'(DEPTH*4) + 32'($urandom_range(0, 255));
      else                           a = 32'($urandom_range(0, 63));
      send(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), a, $urandom);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    drain();
    for (int i = 0; i < 16; i++) check($sformatf("final_word_%0d", i), bram[i], ref_word(i));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
